wb_stage_mc: RTL and testbench
==============================

# wb_stage_mc

Parametrised write-back stage that merges two result sources onto the single register-file write port. The sources are the in-order MEM/WB pipeline result and a long-latency unit (multiplier/divider) result delivered by valid/ready handshake. It adds load byte/halfword extraction with sign/zero extension, a DEPTH-entry result queue for long-latency results, WAW kill of stale queued results, and a pending-register query for the hazard unit. The stage sits between the MEM/WB register and the ID-stage register file, and its outputs are registered.

## Interface
- DATA_W, 32: datapath width; multiple of 16, at least 32.
- REG_AW, 5: register address width.
- DEPTH, 4: long-latency queue depth; power of two, at least 2.
- Derived: LW = $clog2(DATA_W/8); CW = $clog2(DEPTH)+1.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_regwrite  in  1  MEM/WB register-write enable.
- pipe_sel  in  2  result select: 0 ALU, 1 load, 2 link PC, 3 reserved (treated as 0).
- pipe_alu  in  DATA_W  ALU result.
- pipe_mem  in  DATA_W  raw memory read word.
- pipe_pc  in  DATA_W  link value.
- pipe_ld_size  in  2  load size: 0 byte, 1 half, 2 or 3 full width.
- pipe_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- pipe_addr_lo  in  LW  byte offset of the load address.
- pipe_rd  in  REG_AW  destination register.
- lu_valid  in  1  long-unit result valid.
- lu_ready  out  1  queue can accept.
- lu_rd  in  REG_AW  long-unit destination.
- lu_data  in  DATA_W  long-unit result.
- query_rd  in  REG_AW  register probed by the hazard unit.
- query_pending  out  1  live queued write to query_rd exists.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- rf_src  out  1  0 = pipeline, 1 = long unit.
- q_count  out  CW  occupied queue slots, including killed entries.

## Operation
- Pipeline write is live when pipe_regwrite=1 and pipe_rd≠0. A live pipeline write always owns the write port.
- Load data path (pipe_sel=1):
  - byte: lane pipe_addr_lo, bits [8*off+7 : 8*off], extended to DATA_W.
  - half: lane pipe_addr_lo[LW-1:1], little-endian; pipe_addr_lo[0] is ignored.
  - full: pipe_mem unchanged.
- Queue accept: a long-unit result is accepted when lu_valid=1 and lu_ready=1. lu_ready = (q_count < DEPTH) and not reset.
  - When full, there is no same-cycle pass-through, even if the queue drains in that cycle.
- Each queue entry holds {live, rd, data}. An accepted entry with lu_rd=0 is stored with live=0.
- WAW kill: in any cycle with a live pipeline write to X, these entries get live cleared:
  - every queued entry with rd==X;
  - an entry accepted in the same cycle with lu_rd==X.
  - Killed entries keep their slots until they reach the head.
- Drain, evaluated each cycle on the head entry:
  - head live and no live pipeline write: pop it and register the write (rf_src=1).
  - head not live: pop it with no write, regardless of pipeline activity.
  - otherwise: hold.
  - At most one pop per cycle.
- query_pending: combinational OR over queued entries with live=1 and rd==query_rd. It is forced to 0 when query_rd=0, and excludes the entry being accepted this cycle.
- Accept and pop in the same cycle leave q_count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0, q_count=0, queue empty, all live bits 0, lu_ready=0 while reset is high.
- Pipeline to register file: 1 cycle. Inputs sampled at edge N appear on rf_* after edge N and are written at edge N+1.
- Long unit to register file: at least 2 cycles. Accept at edge N, earliest pop at edge N+1, rf_we high after edge N+1.
- Reset asserted mid-operation discards all queued entries and any in-flight write immediately (asynchronous).
- When no write is registered, rf_we=0 and rf_waddr/rf_wdata hold their previous values.

## Test plan
- Reset, then pipe_regwrite=1, pipe_sel=1, pipe_ld_size=0, signed, pipe_addr_lo=2, pipe_mem=0x1280_FF34, pipe_rd=7 -> one cycle later rf_we=1, waddr=7, wdata=0xFFFF_FF80. Repeat with unsigned half, offset 2 -> 0x0000_1280.
- Single lu result rd=9, data=0xDEAD_BEEF, no pipeline traffic -> rf_we with waddr=9 two edges after acceptance, rf_src=1, q_count returns to 0.
- Fill: hold a live pipeline write to rd=3 every cycle and push 5 lu results to distinct rd -> lu_ready=0 after 4 accepts, q_count=4. Release the pipeline -> queue drains in 4 consecutive cycles in FIFO order.
- WAW: queue rd=5 while the pipeline is busy, then pipeline writes rd=5 -> query_pending(5) drops to 0, the queued entry pops without a write, and only the pipeline value is written.
- Same-cycle accept of lu_rd=6 and live pipeline write to rd=6 -> only the pipeline write occurs; the lu entry is killed.
- Assert reset with 3 queued entries -> q_count=0, rf_we=0 immediately, and no stale write after release.

Source files
------------

// File: rtl/wb_stage_mc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_stage_mc_if
//  Description : Bundle of the write-back stage signals: MEM/WB pipeline
//                result, long-unit valid/ready result, hazard-unit query and
//                register-file write port.
//                master : upstream side (pipeline, long unit, hazard unit)
//                slave  : the write-back stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_mc_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
);
    localparam int LW = $clog2(DATA_W / 8);
    localparam int CW = $clog2(DEPTH) + 1;

    // MEM/WB pipeline result
    logic              pipe_regwrite;
    logic [1:0]        pipe_sel;
    logic [DATA_W-1:0] pipe_alu;
    logic [DATA_W-1:0] pipe_mem;
    logic [DATA_W-1:0] pipe_pc;
    logic [1:0]        pipe_ld_size;
    logic              pipe_ld_unsigned;
    logic [LW-1:0]     pipe_addr_lo;
    logic [REG_AW-1:0] pipe_rd;

    // Long-latency unit result handshake
    logic              lu_valid;
    logic              lu_ready;
    logic [REG_AW-1:0] lu_rd;
    logic [DATA_W-1:0] lu_data;

    // Hazard-unit probe
    logic [REG_AW-1:0] query_rd;
    logic              query_pending;

    // Register-file write port and status
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_src;
    logic [CW-1:0]     q_count;

    modport master (
        output pipe_regwrite, pipe_sel, pipe_alu, pipe_mem, pipe_pc,
               pipe_ld_size, pipe_ld_unsigned, pipe_addr_lo, pipe_rd,
               lu_valid, lu_rd, lu_data, query_rd,
        input  lu_ready, query_pending, rf_we, rf_waddr, rf_wdata, rf_src,
               q_count
    );

    modport slave (
        input  pipe_regwrite, pipe_sel, pipe_alu, pipe_mem, pipe_pc,
               pipe_ld_size, pipe_ld_unsigned, pipe_addr_lo, pipe_rd,
               lu_valid, lu_rd, lu_data, query_rd,
        output lu_ready, query_pending, rf_we, rf_waddr, rf_wdata, rf_src,
               q_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wb_stage_mc
//  Description : Write-back stage merging the in-order MEM/WB result and a
//                long-latency unit result onto one register-file write port.
//                Performs load byte/half extraction with sign/zero extension,
//                buffers long-unit results in a DEPTH-entry FIFO, kills stale
//                queued results on a WAW hit and reports pending queued
//                writes to the hazard unit. rf_* outputs are registered.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-high reset
//                bus   - wb_stage_mc_if.slave (pipeline, long unit, query,
//                        register-file write port, queue occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_mc #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_stage_mc_if.slave bus
);
    localparam int LW = $clog2(DATA_W / 8);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [PW-1:0] c_ptr_one = PW'(1);

    localparam logic [1:0] c_sel_load = 2'd1;
    localparam logic [1:0] c_sel_link = 2'd2;
    localparam logic [1:0] c_size_b   = 2'd0;
    localparam logic [1:0] c_size_h   = 2'd1;

    // ------------------------------------------------------------------
    // Queue storage. Live bits are reset; rd/data are only meaningful
    // while their live bit is set, so they need no reset.
    // ------------------------------------------------------------------
    logic              r_q_live [DEPTH];
    logic [REG_AW-1:0] r_q_rd   [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Registered write port
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_rf_src;

    // Combinational control
    logic              w_pipe_live;
    logic              w_lu_ready;
    logic              w_accept;
    logic              w_acc_live;
    logic              w_empty;
    logic              w_head_live;
    logic              w_pop;
    logic              w_query_pending;

    // Load datapath
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_pipe_val;

    // ------------------------------------------------------------------
    // Load extraction: little-endian lanes selected by the low address
    // bits; for halfwords the lowest address bit is dropped.
    // ------------------------------------------------------------------
    assign w_byte = 8'(bus.pipe_mem >> {bus.pipe_addr_lo, 3'b000});
    assign w_half = 16'(bus.pipe_mem >> {bus.pipe_addr_lo[LW-1:1], 4'b0000});

    always_comb begin
        w_load = bus.pipe_mem;
        case (bus.pipe_ld_size)
            c_size_b: w_load = {{(DATA_W-8){~bus.pipe_ld_unsigned & w_byte[7]}}, w_byte};
            c_size_h: w_load = {{(DATA_W-16){~bus.pipe_ld_unsigned & w_half[15]}}, w_half};
            default:  w_load = bus.pipe_mem;
        endcase
    end

    // Select 3 is reserved and falls back to the ALU result.
    always_comb begin
        w_pipe_val = bus.pipe_alu;
        case (bus.pipe_sel)
            c_sel_load: w_pipe_val = w_load;
            c_sel_link: w_pipe_val = bus.pipe_pc;
            default:    w_pipe_val = bus.pipe_alu;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    assign w_pipe_live = bus.pipe_regwrite && (bus.pipe_rd != '0);

    // Readiness depends only on the current occupancy: a full queue never
    // accepts, even when its head drains in the same cycle.
    assign w_lu_ready  = (r_count < c_depth) && !reset;
    assign w_accept    = bus.lu_valid && w_lu_ready;

    // A result for x0, or one overwritten by a same-cycle pipeline write,
    // enters the queue already dead and only occupies a slot.
    assign w_acc_live  = (bus.lu_rd != '0) &&
                         !(w_pipe_live && (bus.lu_rd == bus.pipe_rd));

    assign w_empty     = (r_count == '0);
    assign w_head_live = r_q_live[r_rd_ptr];

    // Dead heads are discarded at once; live heads wait for an idle port.
    assign w_pop       = !w_empty && (!w_head_live || !w_pipe_live);

    // Unoccupied slots always have live=0, so scanning every slot is safe.
    always_comb begin
        w_query_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_q_live[i] && (r_q_rd[i] == bus.query_rd)) begin
                w_query_pending = 1'b1;
            end
        end
        if (bus.query_rd == '0) begin
            w_query_pending = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Queue state, occupancy and write-port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_live[i] <= 1'b0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_rf_src   <= 1'b0;
        end else begin
            // WAW kill of every queued entry targeting the pipeline's rd.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pipe_live && (r_q_rd[i] == bus.pipe_rd)) begin
                    r_q_live[i] <= 1'b0;
                end
            end

            if (w_pop) begin
                r_q_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr           <= r_rd_ptr + c_ptr_one;
            end

            // Accept slot is never the head of an occupied queue, so this
            // cannot collide with the pop clear above.
            if (w_accept) begin
                r_q_live[r_wr_ptr] <= w_acc_live;
                r_wr_ptr           <= r_wr_ptr + c_ptr_one;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            // Address/data/source hold their last value when idle.
            if (w_pipe_live) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= bus.pipe_rd;
                r_rf_wdata <= w_pipe_val;
                r_rf_src   <= 1'b0;
            end else if (w_pop && w_head_live) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= r_q_rd[r_rd_ptr];
                r_rf_wdata <= r_q_data[r_rd_ptr];
                r_rf_src   <= 1'b1;
            end else begin
                r_rf_we    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_rd[r_wr_ptr]   <= bus.lu_rd;
            r_q_data[r_wr_ptr] <= bus.lu_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.lu_ready      = w_lu_ready;
    assign bus.query_pending = w_query_pending;
    assign bus.rf_we         = r_rf_we;
    assign bus.rf_waddr      = r_rf_waddr;
    assign bus.rf_wdata      = r_rf_wdata;
    assign bus.rf_src        = r_rf_src;
    assign bus.q_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage_mc
//  Description : Self-checking bench for wb_stage_mc. A queue-based reference
//                model predicts write-port, occupancy, ready and pending
//                outputs; directed scenarios plus randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_mc;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    wb_stage_mc_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

    wb_stage_mc #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        exp_we    = 1'b0;
    logic        exp_src   = 1'b0;
    logic [4:0]  exp_waddr = '0;
    logic [31:0] exp_wdata = '0;
    int          n_cmp     = 0;
    int          n_fail    = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_pipe_value();
        logic [31:0] v;
        int          off;
        off = int'(bus.pipe_addr_lo);
        case (bus.pipe_sel)
            2'd1: begin
                if (bus.pipe_ld_size == 2'd0) begin
                    v = (bus.pipe_mem >> (8 * off)) & 32'h0000_00FF;
                    if (!bus.pipe_ld_unsigned && v[7]) v = v | 32'hFFFF_FF00;
                end else if (bus.pipe_ld_size == 2'd1) begin
                    v = (bus.pipe_mem >> (8 * (off & 2))) & 32'h0000_FFFF;
                    if (!bus.pipe_ld_unsigned && v[15]) v = v | 32'hFFFF_0000;
                end else begin
                    v = bus.pipe_mem;
                end
            end
            2'd2:    v = bus.pipe_pc;
            default: v = bus.pipe_alu;
        endcase
        return v;
    endfunction

    function automatic bit ref_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit ref_pending(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_we    = 1'b0;
        exp_src   = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
    endtask

    // Advance one clock edge, updating the model with the inputs presented.
    task automatic tick();
        bit          pl, acc, pop;
        logic        nwe, nsrc;
        logic [4:0]  na, prd;
        logic [31:0] nd;
        ent_t        ne;
        prd     = bus.pipe_rd;
        pl      = bus.pipe_regwrite && (prd != 5'd0);
        acc     = bus.lu_valid && ref_ready();
        ne.live = (bus.lu_rd != 5'd0) && !(pl && bus.lu_rd == prd);
        ne.rd   = bus.lu_rd;
        ne.data = bus.lu_data;
        pop  = 1'b0;
        nwe  = 1'b0;
        nsrc = exp_src;
        na   = exp_waddr;
        nd   = exp_wdata;
        if (pl) begin
            nwe = 1'b1; nsrc = 1'b0; na = prd; nd = ref_pipe_value();
        end
        if (mq.size() > 0) begin
            if (!mq[0].live) begin
                pop = 1'b1;
            end else if (!pl) begin
                pop = 1'b1; nwe = 1'b1; nsrc = 1'b1; na = mq[0].rd; nd = mq[0].data;
            end
        end
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (pl) foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
        if (acc) mq.push_back(ne);
        exp_we    = nwe;
        exp_src   = nsrc;
        exp_waddr = na;
        exp_wdata = nd;
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_regwrite    = 1'b0;
        bus.pipe_sel         = 2'd0;
        bus.pipe_alu         = '0;
        bus.pipe_mem         = '0;
        bus.pipe_pc          = '0;
        bus.pipe_ld_size     = 2'd0;
        bus.pipe_ld_unsigned = 1'b0;
        bus.pipe_addr_lo     = '0;
        bus.pipe_rd          = '0;
        bus.lu_valid         = 1'b0;
        bus.lu_rd            = '0;
        bus.lu_data          = '0;
        bus.query_rd         = '0;
    endtask

    task automatic pipe_alu_write(input logic [4:0] rd, input logic [31:0] val);
        bus.pipe_regwrite = 1'b1;
        bus.pipe_sel      = 2'd0;
        bus.pipe_alu      = val;
        bus.pipe_rd       = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_rf: got we=%0b src=%0b addr=%0d data=%h want all zero",
                     bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata);
        end
        n_cmp++;
        if (bus.q_count !== 3'd0 || bus.lu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_queue: got q_count=%0d lu_ready=%0b want 0 0",
                     bus.q_count, bus.lu_ready);
        end
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.lu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %0b want 1", bus.lu_ready);
        end
    endtask

    task automatic test_load();
        idle_inputs();
        bus.pipe_regwrite = 1'b1;
        bus.pipe_sel      = 2'd1;
        bus.pipe_ld_size  = 2'd0;
        bus.pipe_addr_lo  = 2'd2;
        bus.pipe_mem      = 32'h1280_FF34;
        bus.pipe_rd       = 5'd7;
        tick();
        n_cmp++;
        if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 1'b0, 5'd7, 32'hFFFF_FF80}) begin
            n_fail++;
            $display("FAIL load_sbyte: got we=%0b src=%0b addr=%0d data=%h want 1 0 7 ffffff80",
                     bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata);
        end
        bus.pipe_ld_size     = 2'd1;
        bus.pipe_ld_unsigned = 1'b1;
        tick();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'h0000_1280}) begin
            n_fail++;
            $display("FAIL load_uhalf: got we=%0b addr=%0d data=%h want 1 7 00001280",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        for (int k = 0; k < 24; k++) begin
            bus.pipe_sel         = 2'($urandom_range(3, 0));
            bus.pipe_ld_size     = 2'($urandom_range(3, 0));
            bus.pipe_ld_unsigned = 1'($urandom_range(1, 0));
            bus.pipe_addr_lo     = 2'($urandom_range(3, 0));
            bus.pipe_mem         = $urandom;
            bus.pipe_alu         = $urandom;
            bus.pipe_pc          = $urandom;
            bus.pipe_rd          = 5'($urandom_range(31, 1));
            tick();
            n_cmp++;
            if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata} !== {exp_we, exp_src, exp_waddr, exp_wdata}) begin
                n_fail++;
                $display("FAIL load_rand[%0d]: got we=%0b addr=%0d data=%h want we=%0b addr=%0d data=%h",
                         k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_we, exp_waddr, exp_wdata);
            end
        end
        idle_inputs();
        tick();
        n_cmp++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, exp_waddr, exp_wdata}) begin
            n_fail++;
            $display("FAIL idle_hold: got we=%0b addr=%0d data=%h want 0 %0d %h",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_waddr, exp_wdata);
        end
    endtask

    task automatic test_single_lu();
        idle_inputs();
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd9;
        bus.lu_data  = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.q_count !== 3'd1) begin
            n_fail++;
            $display("FAIL lu_accept: got we=%0b q_count=%0d want 0 1", bus.rf_we, bus.q_count);
        end
        tick();
        n_cmp++;
        if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, bus.q_count} !==
            {1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 3'd0}) begin
            n_fail++;
            $display("FAIL lu_write: got we=%0b src=%0b addr=%0d data=%h q=%0d want 1 1 9 deadbeef 0",
                     bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, bus.q_count);
        end
    endtask

    task automatic test_fill();
        int acc = 0;
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            pipe_alu_write(5'd3, $urandom);
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'(10 + acc);
            bus.lu_data  = 32'hA000_0000 + 32'(acc);
            #1;
            if (c >= 4) begin
                n_cmp++;
                if (bus.lu_ready !== 1'b0 || bus.q_count !== 3'd4) begin
                    n_fail++;
                    $display("FAIL fill_full[%0d]: got ready=%0b q=%0d want 0 4", c, bus.lu_ready, bus.q_count);
                end
            end
            if (ref_ready()) acc++;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata} !==
                {1'b1, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i)}) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: got we=%0b src=%0b addr=%0d data=%h want 1 1 %0d %h",
                         i, bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, 10 + i, 32'hA000_0000 + 32'(i));
            end
        end
        n_cmp++;
        if (bus.q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_empty: got q=%0d want 0", bus.q_count);
        end
    endtask

    task automatic test_waw();
        idle_inputs();
        pipe_alu_write(5'd3, 32'h3333_3333);
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd5;
        bus.lu_data  = 32'h0000_0055;
        tick();
        bus.lu_valid = 1'b0;
        bus.query_rd = 5'd5;
        #1;
        n_cmp++;
        if (bus.query_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_pending_before: got %0b want 1", bus.query_pending);
        end
        tick();
        pipe_alu_write(5'd5, 32'h5555_0000);
        tick();
        n_cmp++;
        if (bus.query_pending !== 1'b0 || bus.q_count !== 3'd1) begin
            n_fail++;
            $display("FAIL waw_killed: got pending=%0b q=%0d want 0 1", bus.query_pending, bus.q_count);
        end
        n_cmp++;
        if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 1'b0, 5'd5, 32'h5555_0000}) begin
            n_fail++;
            $display("FAIL waw_pipe_write: got we=%0b src=%0b addr=%0d data=%h want 1 0 5 55550000",
                     bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata);
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL waw_dead_pop: got we=%0b q=%0d want 0 0", bus.rf_we, bus.q_count);
        end
    endtask

    task automatic test_same_cycle_kill();
        idle_inputs();
        pipe_alu_write(5'd6, 32'h0000_0066);
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd6;
        bus.lu_data  = 32'h0000_0077;
        tick();
        idle_inputs();
        bus.query_rd = 5'd6;
        #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, bus.q_count, bus.query_pending} !==
            {1'b1, 1'b0, 5'd6, 32'h0000_0066, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL same_cycle: got we=%0b src=%0b addr=%0d data=%h q=%0d pend=%0b want 1 0 6 66 1 0",
                     bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, bus.q_count, bus.query_pending);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus.rf_we !== 1'b0 || bus.q_count !== 3'd0) begin
                n_fail++;
                $display("FAIL same_cycle_after[%0d]: got we=%0b q=%0d want 0 0", i, bus.rf_we, bus.q_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            pipe_alu_write(5'd3, $urandom);
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'(20 + i);
            bus.lu_data  = $urandom;
            tick();
        end
        bus.lu_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.q_count !== 3'd3 || bus.rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got q=%0d we=%0b want 3 1", bus.q_count, bus.rf_we);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.q_count !== 3'd0 || bus.rf_we !== 1'b0 || bus.lu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got q=%0d we=%0b ready=%0b want 0 0 0",
                     bus.q_count, bus.rf_we, bus.lu_ready);
        end
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.rf_we !== 1'b0 || bus.q_count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_mid_stale[%0d]: got we=%0b q=%0d want 0 0", i, bus.rf_we, bus.q_count);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.pipe_regwrite    = ($urandom_range(99, 0) < 55);
            bus.pipe_sel         = 2'($urandom_range(3, 0));
            bus.pipe_alu         = $urandom;
            bus.pipe_mem         = $urandom;
            bus.pipe_pc          = $urandom;
            bus.pipe_ld_size     = 2'($urandom_range(3, 0));
            bus.pipe_ld_unsigned = 1'($urandom_range(1, 0));
            bus.pipe_addr_lo     = 2'($urandom_range(3, 0));
            bus.pipe_rd          = 5'($urandom_range(7, 0));
            bus.lu_valid         = ($urandom_range(99, 0) < 60);
            bus.lu_rd            = 5'($urandom_range(7, 0));
            bus.lu_data          = $urandom;
            bus.query_rd         = 5'($urandom_range(7, 0));
            #1;
            n_cmp++;
            if (bus.lu_ready !== ref_ready() || bus.query_pending !== ref_pending(bus.query_rd)) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got ready=%0b pend=%0b want %0b %0b",
                         c, bus.lu_ready, bus.query_pending, ref_ready(), ref_pending(bus.query_rd));
            end
            tick();
            n_cmp++;
            if ({bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, bus.q_count} !==
                {exp_we, exp_src, exp_waddr, exp_wdata, 3'(mq.size())}) begin
                n_fail++;
                $display("FAIL rand_port[%0d]: got we=%0b src=%0b addr=%0d data=%h q=%0d want %0b %0b %0d %h %0d",
                         c, bus.rf_we, bus.rf_src, bus.rf_waddr, bus.rf_wdata, bus.q_count,
                         exp_we, exp_src, exp_waddr, exp_wdata, mq.size());
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_load();
        test_single_lu();
        test_fill();
        test_waw();
        test_same_cycle_kill();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
